// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI register-file controller.
package spi_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_CMD   = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  // Command byte layout: {rw, inc, addr[5:0]}
  localparam int RW_BIT   = 7;
  localparam int INC_BIT  = 6;
  localparam int ADDR_MSB = 5;
  localparam int ADDR_W   = ADDR_MSB + 1;
  localparam int NSLOT    = 1 << ADDR_W;

  localparam logic [7:0] UNMAPPED_RD = 8'hFF;

endpackage

// File: rtl/spi_reg_rdmux.sv
// Combinational read-data selector over the full 6-bit address space.
module spi_reg_rdmux
  import spi_ctrl_pkg::*;
#(
  parameter int SW_W  = 16,
  parameter int LED_W = 16
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [SW_W-1:0]   switches,
  input  logic [LED_W-1:0]  leds,
  input  logic [7:0]        chip_id,
  output logic [7:0]        rd_byte,
  output logic              unmapped
);

  localparam int NSW  = SW_W / 8;
  localparam int NLED = LED_W / 8;
  localparam int NREG = 1 + NSW + NLED;

  logic [7:0] map_s [NSLOT];

  // Every address slot gets a byte, so the final lookup needs no range guard
  for (genvar g = 0; g < NSLOT; g++) begin : g_map
    if (g == 0) begin : g_id
      assign map_s[g] = chip_id;
    end else if (g <= NSW) begin : g_sw
      assign map_s[g] = switches[8*(g-1) +: 8];
    end else if (g < NREG) begin : g_led
      assign map_s[g] = leds[8*(g-1-NSW) +: 8];
    end else begin : g_unm
      assign map_s[g] = UNMAPPED_RD;
    end
  end

  assign rd_byte  = map_s[addr];
  assign unmapped = (addr >= ADDR_W'(NREG));

endmodule

// File: rtl/spi_regfile_ctrlr.sv
// SPI command decoder driving a small register file: chip ID, switch bytes, LED bytes.
module spi_regfile_ctrlr
  import spi_ctrl_pkg::*;
#(
  parameter logic [7:0] CHIP_ID = 8'h07,
  parameter int         SW_W    = 16,
  parameter int         LED_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             xfer_active,
  input  logic             new_data,
  input  logic [7:0]       din,
  input  logic [SW_W-1:0]  switches,
  output logic [LED_W-1:0] leds,
  output logic [7:0]       dout,
  output logic             err
);

  localparam int NSW  = SW_W / 8;
  localparam int NLED = LED_W / 8;
  localparam int NREG = 1 + NSW + NLED;

  state_t              state_r, state_nxt_s;
  logic [ADDR_W-1:0]   addr_r, addr_nxt_s, addr_inc_s, rd_addr_s;
  logic                burst_r, burst_nxt_s;
  logic [LED_W-1:0]    leds_r;
  logic [7:0]          dout_r, dout_nxt_s, rd_byte_s;
  logic                err_r, err_nxt_s, rd_unmapped_s;
  logic                led_addr_s, wr_ok_s;
  logic [NLED-1:0]     led_we_s;

  assign addr_inc_s = (addr_r == ADDR_W'(NREG-1)) ? {ADDR_W{1'b0}} : addr_r + ADDR_W'(1);
  assign led_addr_s = (addr_r >= ADDR_W'(NSW+1)) && (addr_r < ADDR_W'(NREG));
  // A command byte reads at its own address; inside a burst the next address is read
  assign rd_addr_s  = (state_r == ST_CMD) ? din[ADDR_MSB:0] : addr_inc_s;

  spi_reg_rdmux #(.SW_W(SW_W), .LED_W(LED_W)) u_rdmux (
    .addr     (rd_addr_s),
    .switches (switches),
    .leds     (leds_r),
    .chip_id  (CHIP_ID),
    .rd_byte  (rd_byte_s),
    .unmapped (rd_unmapped_s)
  );

  for (genvar g = 0; g < NLED; g++) begin : g_we
    assign led_we_s[g] = wr_ok_s && (addr_r == ADDR_W'(NSW+1+g));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_CMD;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; a dropped chip select wins over a coincident byte
  always_comb begin
    state_nxt_s = state_r;
    if (!xfer_active) begin
      state_nxt_s = ST_CMD;
    end else if (new_data) begin
      case (state_r)
        ST_CMD:   state_nxt_s = din[RW_BIT] ? ST_READ : ST_WRITE;
        ST_READ:  state_nxt_s = burst_r ? ST_READ : ST_CMD;
        ST_WRITE: state_nxt_s = burst_r ? ST_WRITE : ST_CMD;
        default:  state_nxt_s = ST_CMD;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Datapath next values: address, burst flag, readback byte, write enable, error
  always_comb begin
    addr_nxt_s  = addr_r;
    burst_nxt_s = burst_r;
    dout_nxt_s  = dout_r;
    err_nxt_s   = err_r;
    wr_ok_s     = 1'b0;
    if (!xfer_active) begin
      dout_nxt_s = 8'h00;
    end else if (new_data) begin
      case (state_r)
        ST_CMD: begin
          addr_nxt_s  = din[ADDR_MSB:0];
          burst_nxt_s = din[INC_BIT];
          if (din[RW_BIT]) begin
            dout_nxt_s = rd_byte_s;
            err_nxt_s  = err_r | rd_unmapped_s;
          end else begin
            dout_nxt_s = 8'h00;
          end
        end
        ST_READ: begin
          if (burst_r) begin
            addr_nxt_s = addr_inc_s;
            dout_nxt_s = rd_byte_s;
            err_nxt_s  = err_r | rd_unmapped_s;
          end else begin
            dout_nxt_s = 8'h00;
          end
        end
        ST_WRITE: begin
          wr_ok_s   = led_addr_s;
          err_nxt_s = err_r | !led_addr_s;
          if (burst_r) begin
            addr_nxt_s = addr_inc_s;
          end else begin
            addr_nxt_s = addr_r;
          end
        end
        default: dout_nxt_s = 8'h00;
      endcase
    end else begin
      dout_nxt_s = dout_r;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r  <= {ADDR_W{1'b0}};
      burst_r <= 1'b0;
      leds_r  <= {LED_W{1'b0}};
      dout_r  <= 8'h00;
      err_r   <= 1'b0;
    end else begin
      addr_r  <= addr_nxt_s;
      burst_r <= burst_nxt_s;
      dout_r  <= dout_nxt_s;
      err_r   <= err_nxt_s;
      for (int i = 0; i < NLED; i++) begin
        if (led_we_s[i]) leds_r[8*i +: 8] <= din;
      end
    end
  end

  assign leds = leds_r;
  assign dout = dout_r;
  assign err  = err_r;

endmodule
